// File: rtl/prf_pkg.sv
// Shared defaults and types for the tagged physical register file.
package prf_pkg;

  localparam int PRF_XLEN     = 32;
  localparam int PRF_NPRF     = 64;
  localparam int PRF_RD_PORTS = 8;
  localparam int PRF_WR_PORTS = 4;
  localparam int PRF_AL_PORTS = 4;
  localparam int PRF_IW       = $clog2(PRF_NPRF);

  typedef logic [PRF_IW-1:0]   prf_idx_t;
  typedef logic [PRF_XLEN-1:0] prf_dat_t;
  typedef logic [PRF_NPRF-1:0] prf_ready_t;

endpackage

// File: rtl/prf_ready_table.sv
// Per-register ready bits: recovery load > allocate clear > writeback set.
// With PRF_BYPASS_EN defined, a same-cycle writeback also reads as ready.
module prf_ready_table
  import prf_pkg::*;
#(
  parameter int NPRF     = PRF_NPRF,
  parameter int RD_PORTS = PRF_RD_PORTS,
  parameter int WR_PORTS = PRF_WR_PORTS,
  parameter int AL_PORTS = PRF_AL_PORTS
)(
  input  logic                                    i_clock,
  input  logic                                    i_reset,
  input  logic [RD_PORTS-1:0][$clog2(NPRF)-1:0]   i_rd_idx,
  output logic [RD_PORTS-1:0]                     o_rd_rdy,
  input  logic [WR_PORTS-1:0]                     i_wr_en,
  input  logic [WR_PORTS-1:0][$clog2(NPRF)-1:0]   i_wr_idx,
  input  logic [AL_PORTS-1:0]                     i_al_en,
  input  logic [AL_PORTS-1:0][$clog2(NPRF)-1:0]   i_al_idx,
  input  logic                                    i_rst_rdy_en,
  input  logic [NPRF-1:0]                         i_rst_rdy_mask,
  output logic [NPRF-1:0]                         o_prf_rdy
);

  logic [NPRF-1:0] r_rdy;
  logic [NPRF-1:0] w_rdy_next;

  // Later assignments take priority: allocate clears override writeback sets.
  always_comb begin
    w_rdy_next = r_rdy;
    for (int j = 0; j < WR_PORTS; j++) begin
      if (i_wr_en[j]) w_rdy_next[i_wr_idx[j]] = 1'b1;
    end
    for (int k = 0; k < AL_PORTS; k++) begin
      if (i_al_en[k]) w_rdy_next[i_al_idx[k]] = 1'b0;
    end
    if (i_rst_rdy_en) w_rdy_next = i_rst_rdy_mask;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) r_rdy <= '1;
    else         r_rdy <= w_rdy_next;
  end

  genvar gi;
  generate
    for (gi = 0; gi < RD_PORTS; gi++) begin : g_rd
`ifdef PRF_BYPASS_EN
      logic w_hit;
      always_comb begin
        w_hit = 1'b0;
        for (int j = 0; j < WR_PORTS; j++) begin
          if (i_wr_en[j] && (i_wr_idx[j] == i_rd_idx[gi])) w_hit = 1'b1;
        end
      end
      assign o_rd_rdy[gi] = i_reset | w_hit | r_rdy[i_rd_idx[gi]];
`else
      assign o_rd_rdy[gi] = i_reset | r_rdy[i_rd_idx[gi]];
`endif
    end
  endgenerate

  assign o_prf_rdy = i_reset ? '1 : r_rdy;

endmodule

// File: rtl/prf_tagged.sv
// Physical register file with ready table, used as the operand scoreboard.
// Define PRF_BYPASS_EN to forward same-cycle writeback data/ready to reads.
module prf_tagged
  import prf_pkg::*;
#(
  parameter int XLEN     = PRF_XLEN,
  parameter int NPRF     = PRF_NPRF,
  parameter int RD_PORTS = PRF_RD_PORTS,
  parameter int WR_PORTS = PRF_WR_PORTS,
  parameter int AL_PORTS = PRF_AL_PORTS
)(
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic [RD_PORTS-1:0][$clog2(NPRF)-1:0]   rd_idx,
  output logic [RD_PORTS-1:0][XLEN-1:0]           rd_dat,
  output logic [RD_PORTS-1:0]                     rd_rdy,
  input  logic [WR_PORTS-1:0]                     wr_en,
  input  logic [WR_PORTS-1:0][$clog2(NPRF)-1:0]   wr_idx,
  input  logic [WR_PORTS-1:0][XLEN-1:0]           wr_dat,
  input  logic [AL_PORTS-1:0]                     al_en,
  input  logic [AL_PORTS-1:0][$clog2(NPRF)-1:0]   al_idx,
  input  logic                                    rst_rdy_en,
  input  logic [NPRF-1:0]                         rst_rdy_mask,
  output logic [NPRF-1:0][XLEN-1:0]               prf_regs,
  output logic [NPRF-1:0]                         prf_rdy
);

  logic [NPRF-1:0][XLEN-1:0] r_regs;

  // Ascending port loop: the highest-numbered port's NBA lands last and wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_regs <= '0;
    end else begin
      for (int j = 0; j < WR_PORTS; j++) begin
        if (wr_en[j]) r_regs[wr_idx[j]] <= wr_dat[j];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < RD_PORTS; gi++) begin : g_rd
      logic [XLEN-1:0] w_dat;
      always_comb begin
        w_dat = r_regs[rd_idx[gi]];
`ifdef PRF_BYPASS_EN
        for (int j = 0; j < WR_PORTS; j++) begin
          if (wr_en[j] && (wr_idx[j] == rd_idx[gi])) w_dat = wr_dat[j];
        end
`endif
      end
      assign rd_dat[gi] = reset ? '0 : w_dat;
    end
  endgenerate

  assign prf_regs = reset ? '0 : r_regs;

  prf_ready_table #(
    .NPRF     (NPRF),
    .RD_PORTS (RD_PORTS),
    .WR_PORTS (WR_PORTS),
    .AL_PORTS (AL_PORTS)
  ) u_ready (
    .i_clock        (clock),
    .i_reset        (reset),
    .i_rd_idx       (rd_idx),
    .o_rd_rdy       (rd_rdy),
    .i_wr_en        (wr_en),
    .i_wr_idx       (wr_idx),
    .i_al_en        (al_en),
    .i_al_idx       (al_idx),
    .i_rst_rdy_en   (rst_rdy_en),
    .i_rst_rdy_mask (rst_rdy_mask),
    .o_prf_rdy      (prf_rdy)
  );

endmodule
